// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: load/store sequencer between the RV32I execute stage and a
// single-port data memory. Accepts one access per ls_valid/ls_ready handshake,
// decodes size/signedness/byte enables, runs one req/ack transaction, and
// returns an extended load result. Misaligned, illegal and timed-out accesses
// are reported with one-cycle pulses. Only one access is outstanding.
//
// Ports
//   clk, rst_n        clock (rising edge), async active-low reset
//   ls_valid/ls_ready core handshake; ls_ready is high only in IDLE
//   idata             instruction word ([6:0] opcode, [14:12] funct3)
//   daddr, wdata      byte address and right-justified store data
//   ld_data           extended load result, held until the next load completes
//   done/misalign/illegal/fault  mutually exclusive one-cycle pulses
//   mem_req/mem_we/mem_addr/mem_wdata  request side, held stable until ack
//   mem_rdata/mem_ack  response side

package lsu_mem_ctrl_pkg;
  localparam int MSB = 31;
  localparam int LSB = 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_RESP, ST_ERR} state_e;
  typedef enum logic [1:0] {SZ_B = 2'd0, SZ_H = 2'd1, SZ_W = 2'd2} size_e;
endpackage

module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int XLEN    = MSB - LSB + 1,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ls_valid,
  output logic            ls_ready,
  input  logic [XLEN-1:0] idata,
  input  logic [XLEN-1:0] daddr,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ld_data,
  output logic            done,
  output logic            misalign,
  output logic            illegal,
  output logic            fault,
  output logic            mem_req,
  output logic [3:0]      mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_ack
);

  // Timeout fires at the end of the TIMEOUT-th ISSUE cycle without ack.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [1:0] off;
  logic       unused_idata;

  assign opcode       = idata[6:0];
  assign funct3       = idata[14:12];
  assign off          = daddr[1:0];
  assign unused_idata = ^{idata[XLEN-1:15], idata[11:7]};

  // ---------------- decode of the presented access ----------------
  logic            dec_legal;
  logic            dec_load;
  logic            dec_misalign;
  size_e           dec_size;
  logic [3:0]      dec_we;
  logic [XLEN-1:0] dec_wdata;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    dec_legal    = 1'b0;
    dec_load     = 1'b0;
    dec_misalign = 1'b0;
    dec_size     = SZ_W;
    dec_we       = 4'b0000;
    dec_wdata    = wdata;

    case (funct3[1:0])
      2'b00:   dec_size = SZ_B;
      2'b01:   dec_size = SZ_H;
      default: dec_size = SZ_W;
    endcase

    if (opcode == OP_LOAD) begin
      dec_load  = 1'b1;
      dec_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else if (opcode == OP_STORE) begin
      dec_legal = !funct3[2] && (funct3[1:0] != 2'b11);
    end

    case (dec_size)
      SZ_B: begin
        dec_we    = 4'b0001 << off;
        dec_wdata = {4{wdata[7:0]}};
      end
      SZ_H: begin
        dec_misalign = off[0];
        dec_we       = 4'b0011 << off;
        dec_wdata    = {2{wdata[15:0]}};
      end
      default: begin
        dec_misalign = (off != 2'b00);
        dec_we       = 4'b1111;
      end
    endcase

    if (dec_load) dec_we = 4'b0000;
  end

  // ---------------- transaction state ----------------
  state_e          state_q;
  size_e           size_q;
  logic            uns_q;
  logic            load_q;
  logic [1:0]      off_q;
  logic [15:0]     cnt_q;
  logic            ls_ready_q, mem_req_q;
  logic            done_q, misalign_q, illegal_q, fault_q;
  logic [3:0]      mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q, ld_data_q;

  // Lane extraction from the returned word, using the captured offset.
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [XLEN-1:0] ld_ext;

  always_comb begin
    rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = off_q[1] ? mem_rdata[XLEN-1:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ld_ext = {{(XLEN-8){rd_byte[7] & ~uns_q}}, rd_byte};
      SZ_H:    ld_ext = {{(XLEN-16){rd_half[15] & ~uns_q}}, rd_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
      load_q      <= 1'b0;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      ls_ready_q  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_data_q   <= '0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
      illegal_q   <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
      illegal_q  <= 1'b0;
      fault_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (ls_valid) begin
            ls_ready_q <= 1'b0;
            // Illegal takes priority: a bad encoding has no meaningful size.
            if (!dec_legal) begin
              state_q   <= ST_ERR;
              illegal_q <= 1'b1;
            end else if (dec_misalign) begin
              state_q    <= ST_ERR;
              misalign_q <= 1'b1;
            end else begin
              state_q     <= ST_ISSUE;
              mem_req_q   <= 1'b1;
              mem_addr_q  <= {daddr[XLEN-1:2], 2'b00};
              mem_we_q    <= dec_we;
              mem_wdata_q <= dec_wdata;
              size_q      <= dec_size;
              uns_q       <= funct3[2];
              load_q      <= dec_load;
              off_q       <= off;
              cnt_q       <= '0;
            end
          end
        end
        ST_ISSUE: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            state_q   <= ST_RESP;
            mem_req_q <= 1'b0;
            done_q    <= 1'b1;
            if (load_q) ld_data_q <= ld_ext;
          end else if (cnt_q == TO_LAST) begin
            state_q   <= ST_ERR;
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        ST_RESP, ST_ERR: begin
          state_q    <= ST_IDLE;
          ls_ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          ls_ready_q <= 1'b1;
          mem_req_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ls_ready  = ls_ready_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ld_data   = ld_data_q;
  assign done      = done_q;
  assign misalign  = misalign_q;
  assign illegal   = illegal_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed testbench for lsu_mem_ctrl with TIMEOUT=4. Inputs change 1 ns
// after the rising edge; outputs are sampled at that same point.
module tb_lsu_mem_ctrl;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ls_valid;
  logic            ls_ready;
  logic [XLEN-1:0] idata, daddr, wdata, ld_data;
  logic            done, misalign, illegal, fault;
  logic            mem_req;
  logic [3:0]      mem_we;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic            mem_ack;

  int n_checks = 0;
  int n_fail   = 0;
  int req_cyc;

  lsu_mem_ctrl #(.XLEN(XLEN), .TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ls_valid  (ls_valid),
    .ls_ready  (ls_ready),
    .idata     (idata),
    .daddr     (daddr),
    .wdata     (wdata),
    .ld_data   (ld_data),
    .done      (done),
    .misalign  (misalign),
    .illegal   (illegal),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3, input logic [6:0] op);
    return {17'b0, f3, 5'b0, op};
  endfunction

  // Present one access for exactly one edge (controller must be in IDLE).
  task automatic accept(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] wd);
    idata    = ins;
    daddr    = a;
    wdata    = wd;
    ls_valid = 1'b1;
    step();
    ls_valid = 1'b0;
  endtask

  // Serve ISSUE: ack in ISSUE cycle (waits+1). Returns cycles mem_req was seen high.
  task automatic serve(input int waits, input logic [31:0] rd, output int n);
    n = 0;
    for (int i = 1; i <= 50; i++) begin
      if (!mem_req) break;
      n = i;
      if (i > waits) begin
        mem_ack   = 1'b1;
        mem_rdata = rd;
      end
      step();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
    end
    check("serve_bound", {31'b0, mem_req}, 32'h0);
  endtask

  function automatic logic [31:0] pulses();
    return {28'b0, done, misalign, illegal, fault};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    ls_valid  = 1'b0;
    idata     = '0;
    daddr     = '0;
    wdata     = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    step();
    step();

    // Reset state
    check("rst_ready", {31'b0, ls_ready}, 32'h1);
    check("rst_req", {31'b0, mem_req}, 32'h0);
    check("rst_we", {28'b0, mem_we}, 32'h0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_ld", ld_data, 32'h0);
    check("rst_pulses", pulses(), 32'h0);
    rst_n = 1'b1;
    step();

    // SB 0x1003, ack after 2 cycles
    accept(mk(3'b000, 7'b0100011), 32'h0000_1003, 32'h0000_00A5);
    check("sb_req", {31'b0, mem_req}, 32'h1);
    check("sb_ready", {31'b0, ls_ready}, 32'h0);
    check("sb_we", {28'b0, mem_we}, 32'h8);
    check("sb_addr", mem_addr, 32'h0000_1000);
    check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    serve(1, 32'h0, req_cyc);
    check("sb_req_cycles", req_cyc, 32'd2);
    check("sb_done", pulses(), 32'h8);
    step();
    check("sb_done_off", pulses(), 32'h0);
    check("sb_ready_back", {31'b0, ls_ready}, 32'h1);

    // LB / LBU from 0x2001
    accept(mk(3'b000, 7'b0000011), 32'h0000_2001, 32'h0);
    check("lb_we", {28'b0, mem_we}, 32'h0);
    serve(0, 32'h1234_8000, req_cyc);
    check("lb_done", pulses(), 32'h8);
    check("lb_data", ld_data, 32'hFFFF_FF80);
    step();
    accept(mk(3'b100, 7'b0000011), 32'h0000_2001, 32'h0);
    serve(0, 32'h1234_8000, req_cyc);
    check("lbu_data", ld_data, 32'h0000_0080);
    step();

    // LHU 0x2002, zero-wait: done two cycles after accept
    accept(mk(3'b101, 7'b0000011), 32'h0000_2002, 32'h0);
    check("lhu_no_early_done", pulses(), 32'h0);
    check("lhu_addr", mem_addr, 32'h0000_2000);
    serve(0, 32'hBEEF_1234, req_cyc);
    check("lhu_req_cycles", req_cyc, 32'd1);
    check("lhu_done", pulses(), 32'h8);
    check("lhu_data", ld_data, 32'h0000_BEEF);
    step();

    // LH sign-extends the low half
    accept(mk(3'b001, 7'b0000011), 32'h0000_2000, 32'h0);
    serve(0, 32'h0000_9ABC, req_cyc);
    check("lh_data", ld_data, 32'hFFFF_9ABC);
    step();

    // Aligned SW must leave ld_data untouched
    accept(mk(3'b010, 7'b0100011), 32'h0000_3000, 32'h1122_3344);
    check("sw_we", {28'b0, mem_we}, 32'hF);
    check("sw_wdata", mem_wdata, 32'h1122_3344);
    serve(0, 32'hDEAD_DEAD, req_cyc);
    check("sw_keeps_ld", ld_data, 32'hFFFF_9ABC);
    step();

    // Misaligned SW at 0x3002
    accept(mk(3'b010, 7'b0100011), 32'h0000_3002, 32'h0);
    check("mis_pulse", pulses(), 32'h4);
    check("mis_no_req", {31'b0, mem_req}, 32'h0);
    check("mis_ready_low", {31'b0, ls_ready}, 32'h0);
    step();
    check("mis_pulse_off", pulses(), 32'h0);
    check("mis_ready_back", {31'b0, ls_ready}, 32'h1);
    check("mis_still_no_req", {31'b0, mem_req}, 32'h0);

    // Illegal opcode, then illegal load funct3
    accept(mk(3'b000, 7'b0110011), 32'h0000_3000, 32'h0);
    check("ill_op_pulse", pulses(), 32'h2);
    check("ill_op_no_req", {31'b0, mem_req}, 32'h0);
    step();
    accept(mk(3'b011, 7'b0000011), 32'h0000_3000, 32'h0);
    check("ill_f3_pulse", pulses(), 32'h2);
    step();
    check("ill_ready_back", {31'b0, ls_ready}, 32'h1);

    // LW with no ack: fault after 4 ISSUE cycles
    accept(mk(3'b010, 7'b0000011), 32'h0000_5000, 32'h0);
    serve(100, 32'h0, req_cyc);
    check("to_req_cycles", req_cyc, 32'd4);
    check("to_fault", pulses(), 32'h1);
    step();
    check("to_fault_off", pulses(), 32'h0);
    check("to_ready_back", {31'b0, ls_ready}, 32'h1);

    // LW with ack in the 4th ISSUE cycle: ack wins
    accept(mk(3'b010, 7'b0000011), 32'h0000_5004, 32'h0);
    serve(3, 32'hCAFE_F00D, req_cyc);
    check("late_req_cycles", req_cyc, 32'd4);
    check("late_done", pulses(), 32'h8);
    check("late_data", ld_data, 32'hCAFE_F00D);
    step();

    // Async reset in the middle of ISSUE
    accept(mk(3'b010, 7'b0000011), 32'h0000_6000, 32'h0);
    step();
    check("mid_in_issue", {31'b0, mem_req}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, mem_req}, 32'h0);
    check("arst_ready", {31'b0, ls_ready}, 32'h1);
    check("arst_addr", mem_addr, 32'h0);
    check("arst_ld", ld_data, 32'h0);
    check("arst_pulses", pulses(), 32'h0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("arst_no_pulse", pulses(), 32'h0);
    rst_n = 1'b1;
    step();
    check("post_rst_pulses", pulses(), 32'h0);

    // Fresh SH at 0x4002
    accept(mk(3'b001, 7'b0100011), 32'h0000_4002, 32'h0000_BEEF);
    check("sh_we", {28'b0, mem_we}, 32'hC);
    check("sh_addr", mem_addr, 32'h0000_4000);
    check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    serve(0, 32'h0, req_cyc);
    check("sh_done", pulses(), 32'h8);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the RV32I execute stage and the single-port data memory.
- Accepts one load or store per handshake and decodes opcode/funct3 to size, signedness and byte enables.
- Issues a req/ack memory transaction, aligns write data, and extracts and extends read data.
- Reports misaligned, illegal and timed-out accesses. Only one access is outstanding at a time.

Parameters:
- XLEN, 32: data and address width; equals MSB-LSB+1 from the parameters package.
- TIMEOUT, 255: maximum cycles mem_req is held without mem_ack before a fault is raised; range 1..65535.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ls_valid  in  1  core presents an access.
- ls_ready  out  1  controller can accept an access.
- idata  in  XLEN  instruction word; [6:0] opcode, [14:12] funct3.
- daddr  in  XLEN  byte address of the access.
- wdata  in  XLEN  store data, right-justified.
- ld_data  out  XLEN  load result, extended.
- done  out  1  one-cycle completion pulse.
- misalign  out  1  one-cycle misaligned-access pulse.
- illegal  out  1  one-cycle pulse for a non-load/store opcode or bad funct3.
- fault  out  1  one-cycle memory-timeout pulse.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  4  byte write enables; 0 for loads.
- mem_addr  out  XLEN  word address: {daddr[XLEN-1:2], 2'b00}.
- mem_wdata  out  XLEN  lane-aligned store data.
- mem_rdata  in  XLEN  memory read word, valid with mem_ack.
- mem_ack  in  1  memory completion.

Behaviour:
- Reset (async, rst_n=0): state IDLE, ls_ready=1, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, ld_data=0, done/misalign/illegal/fault=0, timeout counter=0. Reset mid-transaction abandons it; no pulse is generated.
- Accept condition: ls_valid & ls_ready, in IDLE only. ls_ready=1 only in IDLE. The controller captures idata fields, daddr and wdata at accept.
- Decode:
  - Load: opcode 0000011; funct3 LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Store: opcode 0100011; funct3 SB=000, SH=001, SW=010.
  - Any other opcode or funct3 is illegal.
- Alignment: halfword requires daddr[0]=0; word requires daddr[1:0]=00.
- Byte enables:
  - SB: 0001<<daddr[1:0].
  - SH: 0011<<daddr[1:0].
  - SW: 1111.
  - Loads: 0000.
- Write data: byte replicated to all 4 lanes; halfword replicated to both halves; word unchanged.
- States:
  - IDLE -> ISSUE on a legal, aligned accept.
  - IDLE -> ERR on a misaligned or illegal accept.
  - ISSUE: mem_req=1 and mem_addr/mem_we/mem_wdata stable. On mem_ack -> RESP. If the counter reaches TIMEOUT without ack -> ERR(fault).
  - RESP: done=1 for one cycle, then -> IDLE.
  - ERR: exactly one of misalign/illegal/fault =1 for one cycle, then -> IDLE. No memory request is made for misalign or illegal.
- Latency:
  - Accept in cycle T gives mem_req=1 from T+1.
  - mem_ack sampled in cycle A gives done and the final ld_data in A+1, and ls_ready=1 in A+2.
  - Zero-wait memory (ack in T+1) gives done at T+2.
- mem_req drops in the cycle after ack or timeout.
- Load result, registered on ack:
  - Lane selected by daddr[1:0] (byte) or daddr[1] (half).
  - LB/LH sign-extend; LBU/LHU zero-extend; LW unchanged.
  - ld_data holds its value until the next completed load; stores do not modify it.
- Timeout counter: cleared on entering ISSUE; increments each ISSUE cycle without ack. An ack in the same cycle the count reaches TIMEOUT wins (-> RESP, no fault).
- mem_ack outside ISSUE is ignored. ls_valid while busy is ignored; the core must hold its request until ls_ready.
- Single-cycle pulses never overlap one another.

Test Plan:
- SB, daddr=0x1003, wdata=0x000000A5, ack after 2 cycles -> mem_we=1000, mem_addr=0x1000, mem_wdata=0xA5A5A5A5, mem_req high 2 cycles, done pulse one cycle after ack.
- LB from daddr=0x2001, mem_rdata=0x12348000; then LBU, same address -> LB ld_data=0xFFFFFF80; LBU ld_data=0x00000080.
- LHU, daddr=0x2002, mem_rdata=0xBEEF1234 -> ld_data=0x0000BEEF; zero-wait ack gives done exactly 2 cycles after accept.
- SW at daddr=0x3002 -> misalign pulse at T+1, mem_req never asserted, ls_ready=1 at T+2. Then opcode 0110011 -> illegal pulse only.
- TIMEOUT=4, LW with mem_ack held 0 -> mem_req high 4 cycles, then fault pulse, then IDLE. Next LW with ack in the 4th ISSUE cycle -> done, no fault.
- rst_n asserted low mid-ISSUE -> all outputs return to reset values immediately (async), no done/fault pulse. After release, a fresh SH at 0x4002 yields mem_we=1100.
